tdm_frame_collector: RTL and testbench

//  Downstream stage of the shared TDM FIR: consumes the time-multiplexed filtered sample stream
//  (one sample/cycle max, tagged with its channel index) and reassembles complete frames of
//  NUM_CHANNELS samples into a double-buffered, channel-parallel output with a valid/ready handshake.

---
 rtl/tdm_pkg.sv | 17 +
 rtl/tdm_chan_tracker.sv | 41 ++++
 rtl/tdm_frame_collector.sv | 157 +++++++++++++++
 tb/tb_tdm_frame_collector.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM FIR output collector.
package tdm_pkg;

  localparam int TDM_DATA_WIDTH   = 16;
  localparam int TDM_NUM_CHANNELS = 4;
  localparam int TDM_CHAN_W       = $clog2(TDM_NUM_CHANNELS);
  localparam int TDM_CNT_W        = 16;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PENDING = 2'd1,
    DISCARD = 2'd2
  } tdm_collect_state_e;

  typedef logic [TDM_DATA_WIDTH-1:0] tdm_sample_t;

endpackage

// File: rtl/tdm_chan_tracker.sv
// Expected-channel counter for the TDM collector: compares incoming tags and
// flags out-of-sequence samples with a registered one-cycle pulse.
module tdm_chan_tracker #(
  parameter int NUM_CHANNELS = 4,
  parameter int CHAN_W       = $clog2(NUM_CHANNELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CHAN_W-1:0] in_chan,
  input  logic              check_en,
  input  logic              restart,
  input  logic              clear,
  input  logic              advance,
  output logic [CHAN_W-1:0] exp_chan,
  output logic              chan_match,
  output logic              seq_error
);

  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NUM_CHANNELS - 1);

  // exp_chan never exceeds N-1, so tags >= N always miss.
  assign chan_match = (in_chan == exp_chan);

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_chan  <= '0;
      seq_error <= 1'b0;
    end else begin
      seq_error <= check_en && in_valid && !chan_match;
      if (restart) begin
        exp_chan <= CHAN_W'(1);
      end else if (clear) begin
        exp_chan <= '0;
      end else if (advance) begin
        exp_chan <= (exp_chan == LAST_CHAN) ? '0 : exp_chan + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_frame_collector.sv
// Reassembles the tagged TDM sample stream into channel-parallel frames behind
// a valid/ready output register, with a one-frame pending hold and drop tracking.
module tdm_frame_collector
  import tdm_pkg::*;
#(
  parameter int DATA_WIDTH   = TDM_DATA_WIDTH,
  parameter int NUM_CHANNELS = TDM_NUM_CHANNELS,
  parameter int CHAN_W       = $clog2(NUM_CHANNELS),
  parameter int CNT_W        = TDM_CNT_W
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_WIDTH-1:0]              in_data,
  input  logic                               in_valid,
  input  logic [CHAN_W-1:0]                  in_chan,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               seq_error,
  output logic                               overrun,
  output logic [CNT_W-1:0]                   drop_count,
  output tdm_collect_state_e                 dbg_state
);

  // Handshake: a frame transfers on any cycle where out_valid && out_ready.
  // out_data is held stable while out_valid is high and out_ready is low.

  tdm_collect_state_e state;
  logic               drop_flag;

  logic [DATA_WIDTH-1:0]                  shadow [NUM_CHANNELS-1];
  logic [(NUM_CHANNELS-1)*DATA_WIDTH-1:0] shadow_flat;
  logic [DATA_WIDTH-1:0]                  last_sample;

  logic [CHAN_W-1:0] exp_chan;
  logic              chan_match;
  logic              free;
  logic              in_is_zero;
  logic              is_last;
  logic              collect_hit;
  logic              collect_miss;
  logic              restart;
  logic              clear;
  logic              drop_inc;

  assign dbg_state = state;

  always_comb begin
    free         = !out_valid || out_ready;
    in_is_zero   = (in_chan == '0);
    is_last      = (in_chan == CHAN_W'(NUM_CHANNELS - 1));
    collect_hit  = (state == COLLECT) && in_valid && chan_match;
    collect_miss = (state == COLLECT) && in_valid && !chan_match;
    restart      = (collect_miss || ((state == DISCARD) && in_valid)) && in_is_zero;
    clear        = (collect_miss && !in_is_zero) || ((state == PENDING) && free);
    // A broken partial frame counts once; a pending frame counts on its first overrun.
    drop_inc     = (collect_miss && (exp_chan != '0)) ||
                   ((state == PENDING) && in_valid && !drop_flag);
  end

  always_comb begin
    shadow_flat = '0;
    for (int c = 0; c < NUM_CHANNELS - 1; c++) begin
      shadow_flat[c*DATA_WIDTH +: DATA_WIDTH] = shadow[c];
    end
  end

  tdm_chan_tracker #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CHAN_W       (CHAN_W)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_chan    (in_chan),
    .check_en   (state == COLLECT),
    .restart    (restart),
    .clear      (clear),
    .advance    (collect_hit),
    .exp_chan   (exp_chan),
    .chan_match (chan_match),
    .seq_error  (seq_error)
  );

  // Shadow bank and last-sample hold carry no reset: stale contents are never presented.
  always_ff @(posedge clk) begin
    if (restart) begin
      shadow[0] <= in_data;
    end else if (collect_hit && !is_last) begin
      for (int c = 0; c < NUM_CHANNELS - 1; c++) begin
        if (in_chan == CHAN_W'(c)) begin
          shadow[c] <= in_data;
        end
      end
    end
    if (collect_hit && is_last && !free) begin
      last_sample <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COLLECT;
      drop_flag  <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      drop_count <= '0;
    end else begin
      overrun <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop_inc && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end

      case (state)
        COLLECT: begin
          if (collect_hit && is_last) begin
            if (free) begin
              out_data  <= {in_data, shadow_flat};
              out_valid <= 1'b1;
            end else begin
              state <= PENDING;
            end
          end else if (collect_miss && !in_is_zero) begin
            state <= DISCARD;
          end
        end

        PENDING: begin
          if (in_valid) begin
            overrun   <= 1'b1;
            drop_flag <= 1'b1;
          end
          if (free) begin
            out_data  <= {last_sample, shadow_flat};
            out_valid <= 1'b1;
            drop_flag <= 1'b0;
            // A sample lost on the transfer cycle still breaks the next frame.
            state     <= (drop_flag || in_valid) ? DISCARD : COLLECT;
          end
        end

        DISCARD: begin
          if (in_valid && in_is_zero) begin
            state <= COLLECT;
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_frame_collector.sv
// Bench for tdm_frame_collector: directed vector table, hand-written corner
// sequences and biased random traffic against a queue-based frame model.
module tb_tdm_frame_collector;
  import tdm_pkg::*;

  localparam int DW       = 16;
  localparam int N        = 4;
  localparam int CW       = 2;
  localparam int CNTW     = 6;
  localparam int FW       = N * DW;
  localparam int DROP_MAX = (1 << CNTW) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic [DW-1:0]      in_data;
  logic               in_valid;
  logic [CW-1:0]      in_chan;
  logic [FW-1:0]      out_data;
  logic               out_valid;
  logic               out_ready;
  logic               seq_error;
  logic               overrun;
  logic [CNTW-1:0]    drop_count;
  tdm_collect_state_e dbg_state;

  tdm_frame_collector #(
    .DATA_WIDTH   (DW),
    .NUM_CHANNELS (N),
    .CNT_W        (CNTW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_chan    (in_chan),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .seq_error  (seq_error),
    .overrun    (overrun),
    .drop_count (drop_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: the partial frame is a queue of samples whose length is
  // the next expected tag; a finished frame waits in m_held when output is busy.
  logic [DW-1:0] m_partial[$];
  logic [FW-1:0] m_held[$];
  logic [FW-1:0] exp_q[$];
  bit            m_disc;
  bit            m_tainted;
  logic [FW-1:0] m_out;
  bit            m_ov;
  bit            m_seq;
  bit            m_ovr;
  int            m_drop;

  function automatic logic [FW-1:0] pack_frame(input logic [DW-1:0] last);
    logic [FW-1:0] f;
    f = '0;
    for (int c = 0; c < N - 1; c++) f[c*DW +: DW] = m_partial[c];
    f[(N-1)*DW +: DW] = last;
    return f;
  endfunction

  function automatic tdm_collect_state_e model_state();
    if (m_held.size() > 0) return PENDING;
    if (m_disc) return DISCARD;
    return COLLECT;
  endfunction

  task automatic model_reset();
    m_partial.delete();
    m_held.delete();
    exp_q.delete();
    m_disc = 0; m_tainted = 0; m_out = '0; m_ov = 0;
    m_seq = 0; m_ovr = 0; m_drop = 0;
  endtask

  task automatic bump_drop();
    if (m_drop < DROP_MAX) m_drop++;
  endtask

  task automatic load(input logic [FW-1:0] f);
    m_out = f;
    m_ov  = 1;
    exp_q.push_back(f);
  endtask

  task automatic model_step(input bit v, input int ch, input logic [DW-1:0] d, input bit rdy);
    bit free;
    logic [FW-1:0] f;
    free  = !m_ov || rdy;
    m_seq = 0;
    m_ovr = 0;
    if (m_ov && rdy) m_ov = 0;
    if (m_held.size() > 0) begin
      if (v) begin
        m_ovr = 1;
        if (!m_tainted) bump_drop();
        m_tainted = 1;
      end
      if (free) begin
        load(m_held.pop_front());
        m_disc    = m_tainted;
        m_tainted = 0;
        m_partial.delete();
      end
    end else if (m_disc) begin
      if (v && ch == 0) begin
        m_partial = {d};
        m_disc    = 0;
      end
    end else if (v) begin
      if (ch == m_partial.size()) begin
        if (ch == N - 1) begin
          f = pack_frame(d);
          m_partial.delete();
          if (free) load(f);
          else begin
            m_held.push_back(f);
            m_tainted = 0;
          end
        end else begin
          m_partial.push_back(d);
        end
      end else begin
        m_seq = 1;
        if (m_partial.size() > 0) bump_drop();
        if (ch == 0) m_partial = {d};
        else begin
          m_partial.delete();
          m_disc = 1;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit v, input int ch, input logic [DW-1:0] d, input bit rdy);
    in_valid  = v;
    in_chan   = CW'(ch);
    in_data   = d;
    out_ready = rdy;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL handshake_extra: got frame %h expected no frame", out_data);
      end else begin
        check("handshake_frame", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
    model_step(v, ch, d, rdy);
    @(posedge clk);
    #1;
    check("out_valid",  64'(out_valid),  64'(m_ov));
    check("out_data",   64'(out_data),   64'(m_out));
    check("seq_error",  64'(seq_error),  64'(m_seq));
    check("overrun",    64'(overrun),    64'(m_ovr));
    check("drop_count", 64'(drop_count), 64'(m_drop));
    check("state",      64'(dbg_state),  64'(model_state()));
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_out_data",   64'(out_data),   64'd0);
    check("rst_seq_error",  64'(seq_error),  64'd0);
    check("rst_overrun",    64'(overrun),    64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_state",      64'(dbg_state),  64'(COLLECT));
    reset = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input bit rdy);
    for (int c = 0; c < N; c++) step(1, c, base + DW'(c), rdy);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit                 v;
    int                 ch;
    logic [DW-1:0]      d;
    bit                 e_valid;
    logic [FW-1:0]      e_data;
    bit                 e_seq;
    int                 e_drop;
    tdm_collect_state_e e_state;
  } vec_t;

  function automatic vec_t mk(input bit v, input int ch, input logic [DW-1:0] d,
                              input bit e_valid, input logic [FW-1:0] e_data,
                              input bit e_seq, input int e_drop, input tdm_collect_state_e e_state);
    vec_t r;
    r.v = v; r.ch = ch; r.d = d; r.e_valid = e_valid; r.e_data = e_data;
    r.e_seq = e_seq; r.e_drop = e_drop; r.e_state = e_state;
    return r;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [FW-1:0] d1, d2, d3, d4, d5, da, db, de, df;
    int ch;
    reset = 1'b1; in_valid = 1'b0; in_chan = '0; in_data = '0; out_ready = 1'b1;

    d1 = 64'h0044_0033_0022_0011;
    d2 = 64'h0404_0303_0202_0101;
    d3 = 64'h0808_0707_0606_0505;
    d4 = 64'h00C3_00C2_00C1_00C0;
    // single frame, back-to-back frames, then a skipped channel with recovery
    vecs.push_back(mk(1, 0, 16'h0011, 0, '0, 0, 0, COLLECT));
    vecs.push_back(mk(1, 1, 16'h0022, 0, '0, 0, 0, COLLECT));
    vecs.push_back(mk(1, 2, 16'h0033, 0, '0, 0, 0, COLLECT));
    vecs.push_back(mk(1, 3, 16'h0044, 1, d1, 0, 0, COLLECT));
    vecs.push_back(mk(0, 0, 16'h0000, 0, d1, 0, 0, COLLECT));
    vecs.push_back(mk(1, 0, 16'h0101, 0, d1, 0, 0, COLLECT));
    vecs.push_back(mk(1, 1, 16'h0202, 0, d1, 0, 0, COLLECT));
    vecs.push_back(mk(1, 2, 16'h0303, 0, d1, 0, 0, COLLECT));
    vecs.push_back(mk(1, 3, 16'h0404, 1, d2, 0, 0, COLLECT));
    vecs.push_back(mk(1, 0, 16'h0505, 0, d2, 0, 0, COLLECT));
    vecs.push_back(mk(1, 1, 16'h0606, 0, d2, 0, 0, COLLECT));
    vecs.push_back(mk(1, 2, 16'h0707, 0, d2, 0, 0, COLLECT));
    vecs.push_back(mk(1, 3, 16'h0808, 1, d3, 0, 0, COLLECT));
    vecs.push_back(mk(1, 0, 16'h00A0, 0, d3, 0, 0, COLLECT));
    vecs.push_back(mk(1, 1, 16'h00A1, 0, d3, 0, 0, COLLECT));
    vecs.push_back(mk(1, 3, 16'h00A3, 0, d3, 1, 1, DISCARD));
    vecs.push_back(mk(1, 1, 16'h00B1, 0, d3, 0, 1, DISCARD));
    vecs.push_back(mk(1, 2, 16'h00B2, 0, d3, 0, 1, DISCARD));
    vecs.push_back(mk(1, 0, 16'h00C0, 0, d3, 0, 1, COLLECT));
    vecs.push_back(mk(1, 1, 16'h00C1, 0, d3, 0, 1, COLLECT));
    vecs.push_back(mk(1, 2, 16'h00C2, 0, d3, 0, 1, COLLECT));
    vecs.push_back(mk(1, 3, 16'h00C3, 1, d4, 0, 1, COLLECT));
    vecs.push_back(mk(0, 0, 16'h0000, 0, d4, 0, 1, COLLECT));

    do_reset(3);

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].ch, vecs[i].d, 1);
      check($sformatf("vec%0d_valid", i), 64'(out_valid),  64'(vecs[i].e_valid));
      check($sformatf("vec%0d_data", i),  64'(out_data),   64'(vecs[i].e_data));
      check($sformatf("vec%0d_seq", i),   64'(seq_error),  64'(vecs[i].e_seq));
      check($sformatf("vec%0d_drop", i),  64'(drop_count), 64'(vecs[i].e_drop));
      check($sformatf("vec%0d_state", i), 64'(dbg_state),  64'(vecs[i].e_state));
    end

    // restart on an early ch0: frame comes from the last four samples
    do_reset(1);
    d5 = 64'h00F3_00F2_00F1_00F0;
    step(1, 0, 16'h00E0, 1);
    step(1, 1, 16'h00E1, 1);
    step(1, 0, 16'h00F0, 1);
    check("restart_seq",   64'(seq_error),  64'd1);
    check("restart_drop",  64'(drop_count), 64'd1);
    check("restart_state", 64'(dbg_state),  64'(COLLECT));
    step(1, 1, 16'h00F1, 1);
    check("restart_seq_clear", 64'(seq_error), 64'd0);
    step(1, 2, 16'h00F2, 1);
    step(1, 3, 16'h00F3, 1);
    check("restart_valid", 64'(out_valid), 64'd1);
    check("restart_data",  64'(out_data),  64'(d5));

    // stalled consumer: second frame pends, next sample overruns, release
    do_reset(1);
    da = 64'h01A3_01A2_01A1_01A0;
    db = 64'h01B3_01B2_01B1_01B0;
    de = 64'h01E3_01E2_01E1_01E0;
    send_frame(16'h01A0, 0);
    check("stall_a_valid", 64'(out_valid), 64'd1);
    check("stall_a_data",  64'(out_data),  64'(da));
    send_frame(16'h01B0, 0);
    check("stall_b_state", 64'(dbg_state), 64'(PENDING));
    check("stall_a_hold",  64'(out_data),  64'(da));
    step(1, 0, 16'h01C0, 0);
    check("stall_overrun", 64'(overrun),    64'd1);
    check("stall_drop",    64'(drop_count), 64'd1);
    step(0, 0, 16'h0000, 1);
    check("stall_b_valid", 64'(out_valid), 64'd1);
    check("stall_b_data",  64'(out_data),  64'(db));
    check("stall_discard", 64'(dbg_state), 64'(DISCARD));
    check("stall_ovr_clr", 64'(overrun),   64'd0);
    step(1, 1, 16'h01D1, 1);
    check("stall_consumed", 64'(out_valid), 64'd0);
    check("stall_no_seq",   64'(seq_error), 64'd0);
    send_frame(16'h01E0, 1);
    check("stall_e_data",  64'(out_data),  64'(de));
    check("stall_e_state", 64'(dbg_state), 64'(COLLECT));

    // reset in the middle of a frame discards it
    do_reset(1);
    df = 64'h02F3_02F2_02F1_02F0;
    step(1, 0, 16'h0290, 1);
    step(1, 1, 16'h0291, 1);
    do_reset(1);
    send_frame(16'h02F0, 1);
    check("midrst_valid", 64'(out_valid), 64'd1);
    check("midrst_data",  64'(out_data),  64'(df));
    check("midrst_drop",  64'(drop_count), 64'd0);

    // biased random traffic against the model
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      ch = (m_disc || m_held.size() > 0) ? 0 : m_partial.size();
      if ($urandom_range(0, 9) >= 8) ch = $urandom_range(0, N - 1);
      step($urandom_range(0, 3) != 0, ch, DW'($urandom), $urandom_range(0, 9) < 6);
    end
    step(0, 0, '0, 1);
    check("rand_leftover_frames", 64'(exp_q.size()), 64'(m_ov ? 1 : 0));

    // drop counter saturation
    do_reset(1);
    for (int i = 0; i < DROP_MAX + 8; i++) begin
      step(1, 0, DW'($urandom), 1);
      step(1, 2, DW'($urandom), 1);
    end
    check("drop_saturated", 64'(drop_count), 64'(DROP_MAX));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
